// File: rtl/gray_rx_decoder_pkg.sv
// Shared types and helpers for the Gray-code receive decoder.
package gray_rx_decoder_pkg;

   // Decoder FSM states; encodings are fixed so debug probes stay stable.
   typedef enum logic [1:0] {
      ST_ACQUIRE = 2'd0,
      ST_TRACK   = 2'd1,
      ST_RESYNC  = 2'd2
   } state_e;

   localparam int GRAY_MAX_W = 32;

   // Gray to binary: b[MSB] = g[MSB], b[i] = b[i+1] ^ g[i].
   // Works on a zero-extended value; leading zeros do not change the low bits.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = '0;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_rx_decoder_if.sv
// Signal bundle between the Gray-code source side and the decoder.
// valid semantics: valid=1 means bin_out is a trusted, tracked position; there is no
// ready/back-pressure, and step_up/step_down/glitch are single-cycle event strobes that
// are only meaningful on the cycle they are high.
interface gray_rx_decoder_if #(
   parameter int W     = 4,
   parameter int ERR_W = 8
);
   import gray_rx_decoder_pkg::*;

   logic [W-1:0]     gray_in;
   logic [W-1:0]     bin_out;
   logic             valid;
   logic             step_up;
   logic             step_down;
   logic             glitch;
   logic [ERR_W-1:0] err_count;
   state_e           state;      // debug view of the decoder FSM

   modport master (
      output gray_in,
      input  bin_out, valid, step_up, step_down, glitch, err_count, state
   );

   modport slave (
      input  gray_in,
      output bin_out, valid, step_up, step_down, glitch, err_count, state
   );
endinterface

// File: rtl/gray_rx_decoder_sync.sv
// Multi-flop synchroniser for the asynchronous Gray bus; Gray coding keeps a
// bus-wide capture coherent because only one bit changes per step.
module gray_rx_decoder_sync #(
   parameter int W      = 4,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] chain [STAGES];

   // Shift the input through STAGES flops, all cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/gray_rx_decoder.sv
// Gray-code receiver: synchronises, decodes, tracks +/-1 steps, flags glitches
// and re-acquires once the input has settled again.
module gray_rx_decoder
   import gray_rx_decoder_pkg::*;
#(
   parameter int W           = 4,
   parameter int SYNC_STAGES = 2,
   parameter int ERR_W       = 8
) (
   input  logic               clk,
   input  logic               rst,
   gray_rx_decoder_if.slave   bus
);

   // After reset the synchroniser still holds zeros, so ACQUIRE waits until the
   // chain has been refilled with post-reset samples before loading bin_out.
   localparam int          FW        = $clog2(SYNC_STAGES + 1);
   localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES);

   logic [W-1:0]     g_s, g_b, g_prev_q;
   state_e           state_q, state_d;
   logic [W-1:0]     bin_q, bin_d;
   logic             valid_q, valid_d;
   logic             up_q, up_d, dn_q, dn_d, gl_q, gl_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [FW-1:0]    fill_q, fill_d;

   gray_rx_decoder_sync #(.W(W), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.gray_in),
      .q   (g_s)
   );

   assign g_b = W'(gray2bin(GRAY_MAX_W'(g_s)));

   // Register FSM state, outputs and the one-cycle-old synchronised code.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_ACQUIRE;
         bin_q    <= '0;
         valid_q  <= 1'b0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         gl_q     <= 1'b0;
         err_q    <= '0;
         fill_q   <= '0;
         g_prev_q <= '0;
      end else begin
         state_q  <= state_d;
         bin_q    <= bin_d;
         valid_q  <= valid_d;
         up_q     <= up_d;
         dn_q     <= dn_d;
         gl_q     <= gl_d;
         err_q    <= err_d;
         fill_q   <= fill_d;
         g_prev_q <= g_s;
      end
   end

   // Next-state and next-output decode: step classification and glitch handling.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      valid_d = valid_q;
      up_d    = 1'b0;
      dn_d    = 1'b0;
      gl_d    = 1'b0;
      err_d   = err_q;
      fill_d  = fill_q;
      case (state_q)
         ST_ACQUIRE: begin
            valid_d = 1'b0;
            if (fill_q == FILL_LAST) begin
               bin_d   = g_b;
               valid_d = 1'b1;
               state_d = ST_TRACK;
            end else begin
               fill_d = fill_q + 1'b1;
            end
         end
         ST_TRACK: begin
            if (g_b == bin_q) begin
               // holding position
            end else if (g_b == bin_q + W'(1)) begin
               bin_d = g_b;
               up_d  = 1'b1;
            end else if (g_b == bin_q - W'(1)) begin
               bin_d = g_b;
               dn_d  = 1'b1;
            end else begin
               gl_d    = 1'b1;
               valid_d = 1'b0;
               state_d = ST_RESYNC;
               if (err_q != '1) err_d = err_q + 1'b1;
            end
         end
         ST_RESYNC: begin
            // Reload silently once the code is seen unchanged on two cycles.
            if (g_s == g_prev_q) begin
               bin_d   = g_b;
               valid_d = 1'b1;
               state_d = ST_TRACK;
            end
         end
         default: state_d = ST_ACQUIRE;
      endcase
   end

   assign bus.bin_out   = bin_q;
   assign bus.valid     = valid_q;
   assign bus.step_up   = up_q;
   assign bus.step_down = dn_q;
   assign bus.glitch    = gl_q;
   assign bus.err_count = err_q;
   assign bus.state     = state_q;

endmodule

// File: tb/tb_gray_rx_decoder.sv
// Self-checking bench for gray_rx_decoder (W=4, SYNC_STAGES=2, ERR_W=8).
module tb_gray_rx_decoder;
   import gray_rx_decoder_pkg::*;

   localparam int W     = 4;
   localparam int ERR_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks   = 0;
   int failures = 0;

   // reference model state
   int m_bin = 0;
   int m_err = 0;
   logic [W-1:0] exp_q[$];

   gray_rx_decoder_if #(.W(W), .ERR_W(ERR_W)) bus ();

   gray_rx_decoder #(.W(W), .SYNC_STAGES(2), .ERR_W(ERR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   always #5 clk = ~clk;

   function automatic int ref_gray2bin(input int g);
      return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
   endfunction

   function automatic logic [W-1:0] ref_bin2gray(input int b);
      logic [W-1:0] g;
      g = W'((b ^ (b >> 1)) & 15);
      return g;
   endfunction

   // driver: apply a code at a falling edge, observe n rising edges (#1 after each)
   int o_up, o_dn, o_gl, o_first, o_multi;
   task automatic drive_watch(input logic [W-1:0] g, input int n);
      o_up = 0; o_dn = 0; o_gl = 0; o_first = 0; o_multi = 0;
      @(negedge clk);
      bus.gray_in = g;
      for (int i = 1; i <= n; i++) begin
         @(posedge clk);
         #1;
         if (bus.step_up)   o_up++;
         if (bus.step_down) o_dn++;
         if (bus.glitch)    o_gl++;
         if ((int'(bus.step_up) + int'(bus.step_down) + int'(bus.glitch)) > 1) o_multi++;
         if ((bus.step_up || bus.step_down || bus.glitch) && o_first == 0) o_first = i;
      end
   endtask

   task automatic do_reset(input logic [W-1:0] g);
      @(negedge clk);
      rst = 1'b1;
      bus.gray_in = g;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      m_bin = ref_gray2bin(int'(g));
      m_err = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.gray_in = 4'b0110;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.bin_out !== 4'd0 || bus.valid !== 1'b0 || bus.step_up !== 1'b0 ||
          bus.step_down !== 1'b0 || bus.glitch !== 1'b0 || bus.err_count !== 8'd0) begin
         failures++;
         $display("FAIL reset_outputs: bin=%0d valid=%b up=%b dn=%b gl=%b err=%0d, want all 0",
                  bus.bin_out, bus.valid, bus.step_up, bus.step_down, bus.glitch, bus.err_count);
      end
      checks++;
      if (bus.state !== ST_ACQUIRE) begin
         failures++;
         $display("FAIL reset_state: got %0d want %0d", bus.state, ST_ACQUIRE);
      end
      @(negedge clk);
      rst = 1'b0;
      drive_watch(4'b0110, 6);
      checks++;
      if (o_up + o_dn + o_gl != 0) begin
         failures++;
         $display("FAIL acquire_pulses: got %0d pulses want 0", o_up + o_dn + o_gl);
      end
      checks++;
      if (bus.valid !== 1'b1 || bus.bin_out !== 4'd4) begin
         failures++;
         $display("FAIL acquire_value: valid=%b bin=%0d want valid=1 bin=4", bus.valid, bus.bin_out);
      end
      m_bin = 4;
      m_err = 0;
   endtask

   task automatic test_count_up();
      logic [W-1:0] codes [4];
      int total_up;
      codes[0] = 4'b0001; codes[1] = 4'b0011; codes[2] = 4'b0010; codes[3] = 4'b0110;
      do_reset(4'b0000);
      checks++;
      if (bus.bin_out !== 4'd0 || bus.valid !== 1'b1) begin
         failures++;
         $display("FAIL count_start: bin=%0d valid=%b want 0/1", bus.bin_out, bus.valid);
      end
      total_up = 0;
      for (int k = 0; k < 4; k++) begin
         drive_watch(codes[k], 4);
         total_up += o_up;
         checks++;
         if (o_up != 1 || o_first != 3 || o_dn + o_gl != 0) begin
            failures++;
            $display("FAIL count_step%0d: up=%0d dn=%0d gl=%0d at=%0d want one up at clk 3",
                     k, o_up, o_dn, o_gl, o_first);
         end
         checks++;
         if (int'(bus.bin_out) != k + 1) begin
            failures++;
            $display("FAIL count_bin%0d: got %0d want %0d", k, bus.bin_out, k + 1);
         end
      end
      checks++;
      if (total_up != 4) begin
         failures++;
         $display("FAIL count_total: got %0d want 4", total_up);
      end
      m_bin = 4;
   endtask

   task automatic test_wrap();
      // walk back down to 0, then 0 -> 15 (down) and 15 -> 0 (up)
      for (int b = 3; b >= 0; b--) begin
         drive_watch(ref_bin2gray(b), 4);
         checks++;
         if (o_dn != 1 || o_up + o_gl != 0 || int'(bus.bin_out) != b) begin
            failures++;
            $display("FAIL walk_down%0d: dn=%0d up=%0d gl=%0d bin=%0d want one down, bin %0d",
                     b, o_dn, o_up, o_gl, bus.bin_out, b);
         end
      end
      drive_watch(4'b1000, 4);
      checks++;
      if (o_dn != 1 || o_first != 3 || o_up + o_gl != 0 || bus.bin_out !== 4'd15) begin
         failures++;
         $display("FAIL wrap_down: dn=%0d at=%0d bin=%0d want one down at 3, bin 15",
                  o_dn, o_first, bus.bin_out);
      end
      drive_watch(4'b0000, 4);
      checks++;
      if (o_up != 1 || o_first != 3 || o_dn + o_gl != 0 || bus.bin_out !== 4'd0) begin
         failures++;
         $display("FAIL wrap_up: up=%0d at=%0d bin=%0d want one up at 3, bin 0",
                  o_up, o_first, bus.bin_out);
      end
      m_bin = 0;
   endtask

   task automatic test_glitch();
      logic saw_glitch;
      logic saw_step;
      saw_glitch = 1'b0;
      saw_step   = 1'b0;
      @(negedge clk);
      bus.gray_in = 4'b0100;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.glitch !== 1'b1 || bus.valid !== 1'b0 || bus.err_count !== 8'd1 || bus.bin_out !== 4'd0) begin
         failures++;
         $display("FAIL glitch_pulse: gl=%b valid=%b err=%0d bin=%0d want 1/0/1/0",
                  bus.glitch, bus.valid, bus.err_count, bus.bin_out);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         if (bus.glitch) saw_glitch = 1'b1;
         if (bus.step_up || bus.step_down) saw_step = 1'b1;
      end
      checks++;
      if (bus.valid !== 1'b1 || bus.bin_out !== 4'd7 || saw_glitch || saw_step || bus.err_count !== 8'd1) begin
         failures++;
         $display("FAIL glitch_resync: valid=%b bin=%0d err=%0d extra_gl=%b step=%b want 1/7/1/0/0",
                  bus.valid, bus.bin_out, bus.err_count, saw_glitch, saw_step);
      end
      m_bin = 7;
      m_err = 1;
   endtask

   task automatic test_random();
      int kind, nb, d, exp_up, exp_dn, exp_gl;
      logic [W-1:0] want;
      for (int it = 0; it < 60; it++) begin
         kind = $urandom_range(0, 2);
         if (kind == 0)      nb = (m_bin + 1) % 16;
         else if (kind == 1) nb = (m_bin + 15) % 16;
         else                nb = $urandom_range(0, 15);
         d = (nb - m_bin + 16) % 16;
         exp_up = (d == 1)  ? 1 : 0;
         exp_dn = (d == 15) ? 1 : 0;
         exp_gl = (d >= 2 && d <= 14) ? 1 : 0;
         if (d != 0) m_bin = nb;
         if (exp_gl == 1 && m_err < 255) m_err++;
         exp_q.push_back(W'(m_bin));
         drive_watch(ref_bin2gray(nb), 6);
         checks++;
         if (o_up != exp_up || o_dn != exp_dn || o_gl != exp_gl || o_multi != 0 ||
             (d != 0 && o_first != 3)) begin
            failures++;
            $display("FAIL rand_pulse%0d: up=%0d dn=%0d gl=%0d multi=%0d at=%0d want %0d/%0d/%0d at 3",
                     it, o_up, o_dn, o_gl, o_multi, o_first, exp_up, exp_dn, exp_gl);
         end
         want = exp_q.pop_front();
         checks++;
         if (bus.bin_out !== want || bus.valid !== 1'b1 || int'(bus.err_count) != m_err) begin
            failures++;
            $display("FAIL rand_state%0d: bin=%0d valid=%b err=%0d want bin=%0d valid=1 err=%0d",
                     it, bus.bin_out, bus.valid, bus.err_count, want, m_err);
         end
      end
   endtask

   task automatic test_saturation();
      int total_gl;
      total_gl = 0;
      for (int it = 0; it < 300; it++) begin
         m_bin = m_bin ^ 8;
         drive_watch(ref_bin2gray(m_bin), 5);
         total_gl += o_gl;
         if (m_err < 255) m_err++;
      end
      checks++;
      if (total_gl != 300) begin
         failures++;
         $display("FAIL sat_glitches: got %0d want 300", total_gl);
      end
      checks++;
      if (bus.err_count !== 8'd255 || m_err != 255) begin
         failures++;
         $display("FAIL sat_count: got %0d want 255", bus.err_count);
      end
      checks++;
      if (bus.valid !== 1'b1 || int'(bus.bin_out) != m_bin) begin
         failures++;
         $display("FAIL sat_track: valid=%b bin=%0d want 1/%0d", bus.valid, bus.bin_out, m_bin);
      end
   endtask

   task automatic test_reset_in_resync();
      do_reset(4'b0000);
      for (int k = 0; k < 4; k++) begin
         m_bin = m_bin ^ 8;
         drive_watch(ref_bin2gray(m_bin), 5);
      end
      m_bin = m_bin ^ 8;
      @(negedge clk);
      bus.gray_in = ref_bin2gray(m_bin);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.state !== ST_RESYNC || bus.err_count !== 8'd5 || bus.glitch !== 1'b1) begin
         failures++;
         $display("FAIL pre_reset: state=%0d err=%0d gl=%b want RESYNC/5/1",
                  bus.state, bus.err_count, bus.glitch);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.err_count !== 8'd0 || bus.valid !== 1'b0 || bus.state !== ST_ACQUIRE ||
          bus.glitch !== 1'b0 || bus.step_up !== 1'b0 || bus.step_down !== 1'b0) begin
         failures++;
         $display("FAIL reset_resync: err=%0d valid=%b state=%0d gl=%b up=%b dn=%b want 0/0/ACQUIRE/0/0/0",
                  bus.err_count, bus.valid, bus.state, bus.glitch, bus.step_up, bus.step_down);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      bus.gray_in = '0;
      test_reset();
      test_count_up();
      test_wrap();
      test_glitch();
      test_random();
      test_saturation();
      test_reset_in_resync();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
